logic_clk_div_multi: RTL and testbench
======================================

LOGIC_CLK_DIV_MULTI -- requirements
Module: logic_clk_div_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divided-clock channels (1..16).
REQ-002 SHALL have parameter COUNTER_BITS, default 32, width of every high/low/phase count field.
REQ-003 SHALL have port master_clk, input, 1, the single clock; all logic is synchronous to it.
REQ-004 SHALL have port master_reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ch_enable, input, NUM_CH, per-channel run request (level).
REQ-006 SHALL have port cfg_high, input, NUM_CH*COUNTER_BITS, per-channel active-level length in master_clk cycles; channel i at bits [i*COUNTER_BITS +: COUNTER_BITS].
REQ-007 SHALL have port cfg_low, input, NUM_CH*COUNTER_BITS, per-channel idle-level length; same packing.
REQ-008 SHALL have port cfg_phase, input, NUM_CH*COUNTER_BITS, per-channel start delay; same packing.
REQ-009 SHALL have port cfg_invert, input, NUM_CH, per-channel output polarity; 1 makes the idle level 1 and the active level 0.
REQ-010 SHALL have port cfg_update, input, 1, single-cycle strobe capturing all cfg_* into per-channel pending registers.
REQ-011 SHALL have port sync_restart, input, 1, single-cycle strobe restarting all enabled channels phase-aligned.
REQ-012 SHALL have port output_clk, output, NUM_CH, registered divided clocks.
REQ-013 SHALL have port period_pulse, output, NUM_CH, one-cycle strobe on the first active cycle of every period.
REQ-014 SHALL have port update_pending, output, NUM_CH, high while captured config awaits application.
REQ-015 SHALL have port running, output, NUM_CH, high while channel is not IDLE.

Function
REQ-016 Each channel SHALL run a four-state FSM: IDLE, PHASE, HIGH, LOW.
REQ-017 Count values of 0 in cfg_high/cfg_low SHALL be treated as 1; cfg_phase of 0 SHALL skip PHASE.
REQ-018 IDLE->PHASE/HIGH SHALL occur when ch_enable[i] is sampled 1; active config is loaded from pending if update_pending[i], else from the live cfg_* inputs.
REQ-019 Timing: enable sampled high at edge k, phase P, high H, low L -> output_clk active for cycles k+P+1..k+P+H, idle for the next L cycles, then repeats with period H+L.
REQ-020 In IDLE and PHASE, output_clk[i] SHALL equal the active invert bit (idle level); in HIGH it SHALL equal the inverse; in LOW it SHALL equal the idle level.
REQ-021 period_pulse[i] SHALL assert exactly on the first HIGH cycle of each period, coincident with output_clk.
REQ-022 A cfg_update strobe SHALL set update_pending for all channels and overwrite any earlier pending values (last strobe wins).
REQ-023 Pending config SHALL be applied only at the LOW->HIGH boundary (end of a full period), never mid-period, keeping output glitch-free; update_pending clears on that same cycle.
REQ-024 ch_enable falling during HIGH or LOW SHALL let the current period complete, then go IDLE; during PHASE, go IDLE on the next cycle.
REQ-025 ch_enable re-asserted before the draining period ends SHALL continue running with no gap.
REQ-026 sync_restart SHALL, on the next cycle, move every enabled channel to PHASE (or HIGH if phase 0), restarting counters and applying pending config immediately; disabled channels are unaffected.
REQ-027 sync_restart and cfg_update in the same cycle SHALL restart using the newly captured values, leaving update_pending clear.
REQ-028 Counters SHALL never wrap: max count 2^COUNTER_BITS-1 runs the full length.
REQ-029 Channels SHALL be fully independent except for shared cfg_update/sync_restart.

Reset
REQ-030 master_reset SHALL, on the clock edge, force all FSMs to IDLE, counters and pending/active config to 0, output_clk=0, period_pulse=0, update_pending=0, running=0.
REQ-031 Reset asserted mid-period SHALL take priority over all other inputs, including sync_restart and cfg_update, in the same cycle.

Verification
REQ-032 H=2, L=3, P=0, ch0 enable at edge 10 -> output_clk[0] high cycles 11-12, low 13-15, high 16-17; period_pulse at 11, 16.
REQ-033 ch0 H=1, L=1; ch1 H=1, L=1, P=1; both enabled, then sync_restart -> ch1 lags ch0 by exactly one cycle, period 2.
REQ-034 Running H=4, L=4; cfg_update to H=1, L=1 issued mid-HIGH -> current 8-cycle period completes unchanged; new period 2; update_pending clears at boundary.
REQ-035 cfg_invert=1, H=3, L=2, enable dropped mid-HIGH -> output low 3, high 2, then stays high in IDLE; running drops on entry to IDLE.
REQ-036 H=0, L=0 -> treated as 1/1, output toggles every cycle; reset asserted mid-run -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/logic_clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel IDLE/PHASE/HIGH/LOW FSM with
// independent high/low/phase lengths, polarity, glitch-free pending config and phase-aligned restart.
module logic_clk_div_multi #(
   parameter int NUM_CH       = 4,
   parameter int COUNTER_BITS = 32
) (
   input  logic                           master_clk,
   input  logic                           master_reset,
   input  logic [NUM_CH-1:0]              ch_enable,
   input  logic [NUM_CH*COUNTER_BITS-1:0] cfg_high,
   input  logic [NUM_CH*COUNTER_BITS-1:0] cfg_low,
   input  logic [NUM_CH*COUNTER_BITS-1:0] cfg_phase,
   input  logic [NUM_CH-1:0]              cfg_invert,
   input  logic                           cfg_update,
   input  logic                           sync_restart,
   output logic [NUM_CH-1:0]              output_clk,
   output logic [NUM_CH-1:0]              period_pulse,
   output logic [NUM_CH-1:0]              update_pending,
   output logic [NUM_CH-1:0]              running
);
   localparam int CB = COUNTER_BITS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PHASE = 2'd1,
      S_HIGH  = 2'd2,
      S_LOW   = 2'd3
   } state_t;

   // Counters hold "cycles remaining minus one"; a zero length still lasts one cycle.
   function automatic logic [CB-1:0] len_m1(input logic [CB-1:0] v);
      if (v == {CB{1'b0}}) begin
         len_m1 = {CB{1'b0}};
      end else begin
         len_m1 = v - CB'(1);
      end
   endfunction

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t        r_state;
      logic [CB-1:0] r_cnt;
      logic [CB-1:0] r_act_high, r_act_low, r_act_phase;
      logic [CB-1:0] r_pend_high, r_pend_low, r_pend_phase;
      logic          r_act_inv, r_pend_inv, r_pend;
      logic          r_out, r_pulse, r_run;
      logic [CB-1:0] w_live_high, w_live_low, w_live_phase;
      logic [CB-1:0] w_src_high, w_src_low, w_src_phase;
      logic          w_src_inv, w_restart, w_start, w_boundary, w_consume;

      assign w_live_high  = cfg_high[g*CB +: CB];
      assign w_live_low   = cfg_low[g*CB +: CB];
      assign w_live_phase = cfg_phase[g*CB +: CB];
      assign w_restart    = sync_restart & ch_enable[g];
      assign w_start      = (r_state == S_IDLE) & ch_enable[g];
      assign w_boundary   = (r_state == S_LOW) & (r_cnt == {CB{1'b0}}) & ch_enable[g];
      assign w_consume    = w_restart | w_start | w_boundary;

      // Config source for any load: fresh capture on restart+update, else pending, else live (idle) or active.
      always_comb begin
         if (w_restart && cfg_update) begin
            w_src_high  = w_live_high;
            w_src_low   = w_live_low;
            w_src_phase = w_live_phase;
            w_src_inv   = cfg_invert[g];
         end else if (r_pend) begin
            w_src_high  = r_pend_high;
            w_src_low   = r_pend_low;
            w_src_phase = r_pend_phase;
            w_src_inv   = r_pend_inv;
         end else if (r_state == S_IDLE) begin
            w_src_high  = w_live_high;
            w_src_low   = w_live_low;
            w_src_phase = w_live_phase;
            w_src_inv   = cfg_invert[g];
         end else begin
            w_src_high  = r_act_high;
            w_src_low   = r_act_low;
            w_src_phase = r_act_phase;
            w_src_inv   = r_act_inv;
         end
      end

      // Channel FSM, config registers and registered outputs.
      always_ff @(posedge master_clk) begin
         if (master_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= {CB{1'b0}};
            r_act_high   <= {CB{1'b0}};
            r_act_low    <= {CB{1'b0}};
            r_act_phase  <= {CB{1'b0}};
            r_act_inv    <= 1'b0;
            r_pend_high  <= {CB{1'b0}};
            r_pend_low   <= {CB{1'b0}};
            r_pend_phase <= {CB{1'b0}};
            r_pend_inv   <= 1'b0;
            r_pend       <= 1'b0;
            r_out        <= 1'b0;
            r_pulse      <= 1'b0;
            r_run        <= 1'b0;
         end else begin
            r_pulse <= 1'b0;
            if (cfg_update) begin
               r_pend_high  <= w_live_high;
               r_pend_low   <= w_live_low;
               r_pend_phase <= w_live_phase;
               r_pend_inv   <= cfg_invert[g];
            end
            if (cfg_update && !w_restart) begin
               r_pend <= 1'b1;
            end else if (w_consume) begin
               r_pend <= 1'b0;
            end else begin
               r_pend <= r_pend;
            end

            if (w_restart || w_start) begin
               r_act_high  <= w_src_high;
               r_act_low   <= w_src_low;
               r_act_phase <= w_src_phase;
               r_act_inv   <= w_src_inv;
               r_run       <= 1'b1;
               if (w_src_phase == {CB{1'b0}}) begin
                  r_state <= S_HIGH;
                  r_cnt   <= len_m1(w_src_high);
                  r_out   <= ~w_src_inv;
                  r_pulse <= 1'b1;
               end else begin
                  r_state <= S_PHASE;
                  r_cnt   <= w_src_phase - CB'(1);
                  r_out   <= w_src_inv;
               end
            end else begin
               case (r_state)
                  S_PHASE: begin
                     if (!ch_enable[g]) begin
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_out   <= r_act_inv;
                     end else if (r_cnt == {CB{1'b0}}) begin
                        r_state <= S_HIGH;
                        r_cnt   <= len_m1(r_act_high);
                        r_out   <= ~r_act_inv;
                        r_pulse <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt - CB'(1);
                     end
                  end
                  S_HIGH: begin
                     if (r_cnt == {CB{1'b0}}) begin
                        r_state <= S_LOW;
                        r_cnt   <= len_m1(r_act_low);
                        r_out   <= r_act_inv;
                     end else begin
                        r_cnt <= r_cnt - CB'(1);
                     end
                  end
                  S_LOW: begin
                     if (r_cnt != {CB{1'b0}}) begin
                        r_cnt <= r_cnt - CB'(1);
                     end else if (!ch_enable[g]) begin
                        r_state <= S_IDLE;
                        r_run   <= 1'b0;
                        r_out   <= r_act_inv;
                     end else begin
                        // Period boundary: the only point where pending config may take effect.
                        r_act_high  <= w_src_high;
                        r_act_low   <= w_src_low;
                        r_act_phase <= w_src_phase;
                        r_act_inv   <= w_src_inv;
                        r_state     <= S_HIGH;
                        r_cnt       <= len_m1(w_src_high);
                        r_out       <= ~w_src_inv;
                        r_pulse     <= 1'b1;
                     end
                  end
                  default: begin
                     r_state <= S_IDLE;
                     r_run   <= 1'b0;
                     r_out   <= r_act_inv;
                  end
               endcase
            end
         end
      end

      assign output_clk[g]     = r_out;
      assign period_pulse[g]   = r_pulse;
      assign update_pending[g] = r_pend;
      assign running[g]        = r_run;
   end

endmodule

// File: tb/tb_logic_clk_div_multi.sv
// Directed self-checking bench for logic_clk_div_multi (2 channels, 8-bit counts).
module tb_logic_clk_div_multi;
   localparam int NCH = 2;
   localparam int CB  = 8;

   logic               clk = 1'b0;
   logic               master_reset;
   logic [NCH-1:0]     ch_enable;
   logic [NCH*CB-1:0]  cfg_high, cfg_low, cfg_phase;
   logic [NCH-1:0]     cfg_invert;
   logic               cfg_update, sync_restart;
   logic [NCH-1:0]     output_clk, period_pulse, update_pending, running;

   int errors = 0;
   int checks = 0;

   logic_clk_div_multi #(.NUM_CH(NCH), .COUNTER_BITS(CB)) dut (
      .master_clk    (clk),
      .master_reset  (master_reset),
      .ch_enable     (ch_enable),
      .cfg_high      (cfg_high),
      .cfg_low       (cfg_low),
      .cfg_phase     (cfg_phase),
      .cfg_invert    (cfg_invert),
      .cfg_update    (cfg_update),
      .sync_restart  (sync_restart),
      .output_clk    (output_clk),
      .period_pulse  (period_pulse),
      .update_pending(update_pending),
      .running       (running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_cfg(input int ch, input logic [CB-1:0] h, input logic [CB-1:0] l,
                          input logic [CB-1:0] p, input logic inv);
      cfg_high[ch*CB +: CB]  = h;
      cfg_low[ch*CB +: CB]   = l;
      cfg_phase[ch*CB +: CB] = p;
      cfg_invert[ch]         = inv;
   endtask

   initial begin
      logic [9:0] e_o10, e_p10;
      logic [6:0] e_o7, e_p7, e_u7, e_r7;
      int n;

      master_reset = 1'b1;
      ch_enable    = '0;
      cfg_high     = '0;
      cfg_low      = '0;
      cfg_phase    = '0;
      cfg_invert   = '0;
      cfg_update   = 1'b0;
      sync_restart = 1'b0;
      tick();
      tick();
      chk("rst_out",  output_clk, 0);
      chk("rst_pls",  period_pulse, 0);
      chk("rst_pend", update_pending, 0);
      chk("rst_run",  running, 0);
      master_reset = 1'b0;
      tick();

      // H=2 L=3 P=0 basic waveform
      set_cfg(0, 8'd2, 8'd3, 8'd0, 1'b0);
      ch_enable = 2'b01;
      e_o10 = 10'b1100011000;
      e_p10 = 10'b1000010000;
      for (int j = 0; j < 10; j++) begin
         tick();
         chk("basic_out", output_clk[0], e_o10[9-j]);
         chk("basic_pls", period_pulse[0], e_p10[9-j]);
      end
      ch_enable = 2'b00;
      tick();
      chk("basic_idle_run", running[0], 0);
      chk("basic_idle_out", output_clk[0], 0);

      // H=0 L=0 behaves as 1/1, then reset mid-run beats both strobes
      set_cfg(0, 8'd0, 8'd0, 8'd0, 1'b0);
      ch_enable = 2'b01;
      for (int j = 0; j < 4; j++) begin
         tick();
         chk("zero_out", output_clk[0], (j % 2 == 0) ? 1 : 0);
      end
      master_reset = 1'b1;
      sync_restart = 1'b1;
      cfg_update   = 1'b1;
      tick();
      chk("midrst_out",  output_clk, 0);
      chk("midrst_pls",  period_pulse, 0);
      chk("midrst_pend", update_pending, 0);
      chk("midrst_run",  running, 0);
      master_reset = 1'b0;
      sync_restart = 1'b0;
      cfg_update   = 1'b0;
      ch_enable    = 2'b00;
      tick();

      // Phase-aligned restart: ch1 lags ch0 by one cycle
      set_cfg(0, 8'd1, 8'd1, 8'd0, 1'b0);
      set_cfg(1, 8'd1, 8'd1, 8'd1, 1'b0);
      ch_enable = 2'b11;
      tick();
      tick();
      tick();
      sync_restart = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tick();
         sync_restart = 1'b0;
         chk("sync_out", output_clk, (j % 2 == 0) ? 2'b01 : 2'b10);
         chk("sync_pls", period_pulse, (j % 2 == 0) ? 2'b01 : 2'b10);
      end

      // Restart and update together: new values apply at once, pending stays clear on ch0
      ch_enable = 2'b01;
      set_cfg(0, 8'd2, 8'd2, 8'd0, 1'b0);
      cfg_update   = 1'b1;
      sync_restart = 1'b1;
      tick();
      cfg_update   = 1'b0;
      sync_restart = 1'b0;
      chk("su_pend", update_pending, 2'b10);
      chk("su_out",  output_clk[0], 1);
      chk("su_pls",  period_pulse[0], 1);
      tick();
      chk("su_out1", output_clk[0], 1);
      tick();
      chk("su_out2", output_clk[0], 0);
      ch_enable = 2'b00;
      tick();
      tick();
      tick();
      chk("su_drain_run", running, 0);

      // Mid-HIGH update only takes effect after the 8-cycle period
      set_cfg(0, 8'd4, 8'd4, 8'd0, 1'b0);
      ch_enable = 2'b01;
      tick();
      tick();
      tick();
      set_cfg(0, 8'd1, 8'd1, 8'd0, 1'b0);
      cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
      set_cfg(0, 8'd7, 8'd7, 8'd0, 1'b0);
      chk("upd_pend_set", update_pending[0], 1);
      chk("upd_out_hold", output_clk[0], 1);
      e_o7 = 7'b0000101;
      e_u7 = 7'b1111000;
      e_p7 = 7'b0000101;
      for (int j = 0; j < 7; j++) begin
         tick();
         chk("upd_out",  output_clk[0], e_o7[6-j]);
         chk("upd_pend", update_pending[0], e_u7[6-j]);
         chk("upd_pls",  period_pulse[0], e_p7[6-j]);
      end
      ch_enable = 2'b00;
      tick();
      tick();
      tick();
      chk("upd_drain_run", running[0], 0);

      // Inverted, enable dropped mid-HIGH: period completes, idles high
      set_cfg(0, 8'd3, 8'd2, 8'd0, 1'b1);
      ch_enable = 2'b01;
      e_o7 = 7'b0001111;
      e_r7 = 7'b1111100;
      for (int j = 0; j < 7; j++) begin
         tick();
         if (j == 1) ch_enable = 2'b00;
         chk("inv_out", output_clk[0], e_o7[6-j]);
         chk("inv_run", running[0], e_r7[6-j]);
      end

      // Phase delay P=2, then enable dropped during PHASE
      set_cfg(0, 8'd1, 8'd1, 8'd2, 1'b0);
      ch_enable = 2'b01;
      tick();
      chk("ph_out0", output_clk[0], 0);
      chk("ph_run0", running[0], 1);
      tick();
      chk("ph_out1", output_clk[0], 0);
      tick();
      chk("ph_out2", output_clk[0], 1);
      chk("ph_pls2", period_pulse[0], 1);
      tick();
      chk("ph_out3", output_clk[0], 0);
      ch_enable = 2'b00;
      tick();
      ch_enable = 2'b01;
      tick();
      chk("phd_run_in", running[0], 1);
      ch_enable = 2'b00;
      tick();
      chk("phd_run_out", running[0], 0);

      // Maximum count runs its full length
      set_cfg(0, 8'd255, 8'd1, 8'd0, 1'b0);
      ch_enable = 2'b01;
      n = 0;
      for (int t = 0; t < 300; t++) begin
         tick();
         if (output_clk[0]) n++;
         else break;
      end
      ch_enable = 2'b00;
      chk("max_high_len", n, 255);
      tick();
      tick();
      chk("max_drain_run", running[0], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
